ctrl_sequencer: RTL
===================

# ctrl_sequencer

Hardwired control sequencer for the single-bus datapath. It runs the instruction fetch (T0–T2) and decodes the opcode in IR[31:27]. It then generates per-cycle register enables, bus-driver selects, ALU op codes, memory strobes and Gra/Grb/Grc/Rin/Rout/BAout for jr, jal, conditional branch, nop and halt. It connects directly to the datapath's control inputs and replaces the hand-written stimulus sequences used so far.

## Interface
Parameters:
- OPC_BR, 5'b10010, conditional-branch opcode
- OPC_JAL, 5'b10011, jump-and-link opcode
- OPC_JR, 5'b10100, jump-register opcode
- OPC_NOP, 5'b11010, no-op opcode
- OPC_HALT, 5'b11011, halt opcode

Ports:
- clk  in  1  clock; all state changes on rising edge
- clr  in  1  reset, asynchronous, active-high
- ir  in  32  datapath IR contents; opcode = ir[31:27]
- con_ff  in  1  CON flip-flop output from datapath
- enable  out  32  register load enables: [15:0]=R0..R15in, [18]=Zin, [20]=PCin, [21]=MDRin, [23]=Yin, [24]=IRin, [25]=MARin
- bus_select  out  32  bus driver selects, one-hot or zero: [19]=ZLowout, [20]=PCout, [21]=MDRout, [23]=Cout
- control_signals  out  5  ALU op: 0=none, 3=ADD, 14=IncPC
- md_read, read_ram, write_ram  out  1 each  memory/MDR strobes
- gra, grb, grc, rin, rout, ba_out  out  1 each  select-and-encode controls
- con_in  out  1  CON flip-flop load enable
- run  out  1  high while sequencing; low in IDLE and HALT
- illegal  out  1  one-cycle pulse in T3 for unsupported opcode

## Operation
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, HALT. The state register is 4 bits. Outputs are Moore-decoded from the state. The only exception is PCin in branch T6, which is gated by con_ff.
- IDLE: all outputs 0. Goes to T0 on the first edge with clr low.
- T0: PCout, MARin, control_signals=14, Zin.
- T1: ZLowout, PCin, MDRin, md_read, read_ram.
- T2: MDRout, IRin.
- T3 decodes ir[31:27], which is valid because IR was loaded at the end of T2:
  - jr: gra, rout, PCin. Next state T0.
  - jal: PCout, R15in (enable[15]). Next state T4; in T4: gra, rout, PCin. Next state T0.
  - br: gra, rout, con_in. T4: PCout, Yin. T5: Cout, control_signals=3, Zin. T6: ZLowout, plus PCin only if con_ff=1. Next state T0.
  - nop: no outputs. Next state T0.
  - halt: no outputs. Next state HALT.
  - any other opcode: illegal=1 for this cycle, no other outputs, then T0. This makes it a nop.
- HALT: all outputs 0, run=0. Left only via clr.
- Every asserted field is exactly the listed bits. All unlisted bits are 0. At most one bus_select bit is set at any time.

## Timing
- Reset: every output is 0 while clr is high and in IDLE. Assertion takes effect immediately (asynchronous). clr in any state forces IDLE; any instruction in progress is abandoned.
- Each T-state lasts exactly one clk cycle.
- Cycles from T0 entry back to T0 entry: nop/illegal 4, jr 4, jal 5, br 7.
- con_ff is sampled combinationally in T6. It was loaded at the end of T3, so it is stable from T4 on.
- write_ram is never asserted by this block (no store support); it is held at 0.
- run=1 in T0–T6.

## Configuration
- BRANCH_EN defined: OPC_BR executes the T3–T6 sequence above.
- BRANCH_EN undefined: OPC_BR is treated as illegal (illegal pulse in T3, then T0). States T5/T6, con_in and Cout are never generated.

## Test plan
- Reset: hold clr 3 cycles → all outputs 0 and run=0. Release clr → T0 asserts enable[25], enable[20]?=0, bus_select[20]=1, control_signals=14.
- Assert clr in T1 → outputs go to 0 asynchronously. After release, T0 restarts.
- jr, datapath PC=13, R5=5, ir=opcode 10100 with ra=5 → T3 shows gra=1, rout=1, enable[20]=1. PC=5 afterwards. Next T0 follows 4 cycles after the prior T0.
- jal, ir=opcode 10011, ra=2, R2=40, PC=13 → T3: bus_select[20], enable[15] (R15=14). T4: PC=40. Instruction takes 5 cycles.
- br with BRANCH_EN, PC=13, C=+6:
  - con_ff=1 → T6 enable[20]=1, PC=20.
  - con_ff=0 → T6 enable[20]=0, PC stays 14.
  - Without BRANCH_EN: illegal=1 in T3.
- halt, ir=opcode 11011 → HALT after T3, run=0, outputs stay 0 for ≥10 cycles until clr.

Source files
------------

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer: hardwired fetch/decode/execute sequencer for the single-bus datapath.
// Supported instructions: jr, jal, nop and halt. Any other opcode pulses illegal in T3
// and then behaves as a nop.
// Optional feature: define BRANCH_EN to execute conditional branches (T3..T6).
// Without it, OPC_BR is treated as illegal.
module ctrl_sequencer #(
  parameter logic [4:0] OPC_BR   = 5'b10010,
  parameter logic [4:0] OPC_JAL  = 5'b10011,
  parameter logic [4:0] OPC_JR   = 5'b10100,
  parameter logic [4:0] OPC_NOP  = 5'b11010,
  parameter logic [4:0] OPC_HALT = 5'b11011
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        con_ff,
  output logic [31:0] enable,
  output logic [31:0] bus_select,
  output logic [4:0]  control_signals,
  output logic        md_read,
  output logic        read_ram,
  output logic        write_ram,
  output logic        gra,
  output logic        grb,
  output logic        grc,
  output logic        rin,
  output logic        rout,
  output logic        ba_out,
  output logic        con_in,
  output logic        run,
  output logic        illegal
);

  localparam int unsigned W_WORD = 32;
  localparam int unsigned W_OP   = 5;
  localparam int unsigned W_ALU  = 5;

  localparam int unsigned EN_R15 = 15;
  localparam int unsigned EN_Z   = 18;
  localparam int unsigned EN_PC  = 20;
  localparam int unsigned EN_MDR = 21;
  localparam int unsigned EN_Y   = 23;
  localparam int unsigned EN_IR  = 24;
  localparam int unsigned EN_MAR = 25;
  localparam int unsigned BS_ZLO = 19;
  localparam int unsigned BS_PC  = 20;
  localparam int unsigned BS_MDR = 21;
  localparam int unsigned BS_C   = 23;

  localparam logic [W_ALU-1:0] ALU_ADD   = W_ALU'(3);
  localparam logic [W_ALU-1:0] ALU_INCPC = W_ALU'(14);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
  } state_e;

  typedef struct packed {
    logic [W_WORD-1:0] en;
    logic [W_WORD-1:0] bs;
    logic [W_ALU-1:0]  alu;
    logic              md_read;
    logic              read_ram;
    logic              gra;
    logic              rout;
    logic              con_in;
    logic              run;
    logic              illegal;
  } ctl_t;

  // Per-state control word. T3 contributes only run; its opcode-dependent part is decoded live from ir.
  function automatic ctl_t moore_ctl(input state_e s, input logic jal, input logic br);
    ctl_t c;
    c = '0;
    case (s)
      S_T0: begin
        c.en[EN_MAR] = 1'b1;
        c.en[EN_Z]   = 1'b1;
        c.bs[BS_PC]  = 1'b1;
        c.alu        = ALU_INCPC;
        c.run        = 1'b1;
      end
      S_T1: begin
        c.bs[BS_ZLO] = 1'b1;
        c.en[EN_PC]  = 1'b1;
        c.en[EN_MDR] = 1'b1;
        c.md_read    = 1'b1;
        c.read_ram   = 1'b1;
        c.run        = 1'b1;
      end
      S_T2: begin
        c.bs[BS_MDR] = 1'b1;
        c.en[EN_IR]  = 1'b1;
        c.run        = 1'b1;
      end
      S_T3: c.run = 1'b1;
      S_T4: begin
        c.run = 1'b1;
        if (jal) begin
          c.gra       = 1'b1;
          c.rout      = 1'b1;
          c.en[EN_PC] = 1'b1;
        end else if (br) begin
          c.bs[BS_PC] = 1'b1;
          c.en[EN_Y]  = 1'b1;
        end
      end
      S_T5: begin
        c.bs[BS_C]  = 1'b1;
        c.alu       = ALU_ADD;
        c.en[EN_Z]  = 1'b1;
        c.run       = 1'b1;
      end
      S_T6: begin
        c.bs[BS_ZLO] = 1'b1;
        c.run        = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  state_e state_q, state_d;
  logic   br_q, br_d;
  ctl_t   ctl_q, ctl_d, t3_ctl, out_ctl;

  logic [W_OP-1:0] opc;
  logic is_jr, is_jal, is_nop, is_halt, br_op, is_br, pc_gate;
  logic unused_bits;

  assign opc     = ir[W_WORD-1 -: W_OP];
  assign is_jr   = (opc == OPC_JR);
  assign is_jal  = (opc == OPC_JAL);
  assign is_nop  = (opc == OPC_NOP);
  assign is_halt = (opc == OPC_HALT);
  assign br_op   = (opc == OPC_BR);

`ifdef BRANCH_EN
  assign is_br   = br_op;
  assign pc_gate = (state_q == S_T6) & br_q & con_ff;
`else
  assign is_br   = 1'b0;
  assign pc_gate = 1'b0;
`endif

  // Operand fields of ir are consumed by the datapath, not here.
  assign unused_bits = ^{ir[W_WORD-W_OP-1:0], con_ff, br_op};

  // Next-state, branch-flag capture and the live T3 opcode decode.
  always_comb begin
    state_d = state_q;
    br_d    = br_q;
    t3_ctl  = '0;
    case (state_q)
      S_IDLE: state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1:   state_d = S_T2;
      S_T2:   state_d = S_T3;
      S_T3: begin
        br_d = is_br;
        if (is_jr) begin
          t3_ctl.gra       = 1'b1;
          t3_ctl.rout      = 1'b1;
          t3_ctl.en[EN_PC] = 1'b1;
          state_d          = S_T0;
        end else if (is_jal) begin
          t3_ctl.bs[BS_PC]  = 1'b1;
          t3_ctl.en[EN_R15] = 1'b1;
          state_d           = S_T4;
        end else if (is_br) begin
          t3_ctl.gra    = 1'b1;
          t3_ctl.rout   = 1'b1;
          t3_ctl.con_in = 1'b1;
          state_d       = S_T4;
        end else if (is_nop) begin
          state_d = S_T0;
        end else if (is_halt) begin
          state_d = S_HALT;
        end else begin
          t3_ctl.illegal = 1'b1;
          state_d        = S_T0;
        end
      end
      S_T4:   state_d = br_q ? S_T5 : S_T0;
      S_T5:   state_d = S_T6;
      S_T6:   state_d = S_T0;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
    ctl_d = moore_ctl(state_d, is_jal, is_br);
  end

  // State and registered control word; clr abandons any instruction in progress.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= S_IDLE;
      br_q    <= 1'b0;
      ctl_q   <= '0;
    end else begin
      state_q <= state_d;
      br_q    <= br_d;
      ctl_q   <= ctl_d;
    end
  end

  // Merge registered word, T3 opcode decode and the con_ff-gated PCin of branch T6.
  always_comb begin
    out_ctl            = ctl_q | t3_ctl;
    out_ctl.en[EN_PC]  = out_ctl.en[EN_PC] | pc_gate;
  end

  assign enable          = out_ctl.en;
  assign bus_select      = out_ctl.bs;
  assign control_signals = out_ctl.alu;
  assign md_read         = out_ctl.md_read;
  assign read_ram        = out_ctl.read_ram;
  assign write_ram       = 1'b0;
  assign gra             = out_ctl.gra;
  assign grb             = 1'b0;
  assign grc             = 1'b0;
  assign rin             = 1'b0;
  assign rout            = out_ctl.rout;
  assign ba_out          = 1'b0;
  assign con_in          = out_ctl.con_in;
  assign run             = out_ctl.run;
  assign illegal         = out_ctl.illegal;

endmodule
